// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side handshake bundle for icache_responder.
// slave = the cache; master = the IF stage plus memory controller side.
interface icache_responder_if;
  logic        fetch_en;
  logic [31:0] fetch_pc;
  logic [31:0] instr_out;
  logic        fetch_success;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_done;

  modport slave (
    input  fetch_en, fetch_pc, mem_data, mem_done,
    output instr_out, fetch_success, mem_req, mem_addr
  );

  modport master (
    output fetch_en, fetch_pc, mem_data, mem_done,
    input  instr_out, fetch_success, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache responder: 1-cycle hits, word-by-word line refill, flush squash.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
//
// state    | meaning
// S_IDLE   | accepting lookups; a hit raises fetch_success on the following cycle
// S_REFILL | fetching the line one word at a time from the memory controller
// S_DONE   | refill finished; success pulse (if not squashed) is visible, then back to IDLE
module icache_responder #(
  parameter int INDEX_BITS     = 6,
  parameter int LINE_WORDS_LOG = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_rdy,
  input  logic                i_flush,
  icache_responder_if.slave   bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]         o_hit_cnt,
  output logic [31:0]         o_miss_cnt
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << LINE_WORDS_LOG;
  localparam int IDX_LSB  = 2 + LINE_WORDS_LOG;
  localparam int TAG_LSB  = IDX_LSB + INDEX_BITS;
  localparam int TAG_BITS = 32 - TAG_LSB;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_DONE} state_t;

  state_t                    r_state;
  logic [31:2]               r_pc;
  logic [LINE_WORDS_LOG-1:0] r_cnt;
  logic                      r_squash;
  logic                      r_success;
  logic [31:0]               r_instr;
  logic                      r_mem_req;
  logic [31:0]               r_mem_addr;
  logic [LINES-1:0]          r_valid;
  logic [TAG_BITS-1:0]       r_tag  [LINES];
  logic [31:0]               r_data [LINES][WORDS];

  logic [INDEX_BITS-1:0]     w_req_idx, w_ref_idx;
  logic [LINE_WORDS_LOG-1:0] w_req_off, w_ref_off;
  logic [TAG_BITS-1:0]       w_req_tag, w_ref_tag;
  logic                      w_hit, w_accept, w_word_wr;
  logic                      w_unused;

  assign w_req_off = bus.fetch_pc[IDX_LSB-1:2];
  assign w_req_idx = bus.fetch_pc[TAG_LSB-1:IDX_LSB];
  assign w_req_tag = bus.fetch_pc[31:TAG_LSB];
  assign w_ref_off = r_pc[IDX_LSB-1:2];
  assign w_ref_idx = r_pc[TAG_LSB-1:IDX_LSB];
  assign w_ref_tag = r_pc[31:TAG_LSB];
  assign w_unused  = &{1'b0, bus.fetch_pc[1:0]};

  assign w_hit     = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  // No new lookup while a success pulse is showing: IF still holds the old request then.
  assign w_accept  = i_rdy && (r_state == S_IDLE) && !r_success && bus.fetch_en && !i_flush;
  assign w_word_wr = i_rdy && (r_state == S_REFILL) && bus.mem_done;

  assign bus.instr_out     = r_instr;
  assign bus.fetch_success = r_success & i_rdy;
  assign bus.mem_req       = r_mem_req;
  assign bus.mem_addr      = r_mem_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_cnt      <= '0;
      r_squash   <= 1'b0;
      r_success  <= 1'b0;
      r_instr    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_valid    <= '0;
    end else if (i_rdy) begin
      case (r_state)
        S_IDLE: begin
          r_success <= 1'b0;
          r_squash  <= 1'b0;
          if (w_accept) begin
            r_pc <= bus.fetch_pc[31:2];
            if (w_hit) begin
              r_success <= 1'b1;
              r_instr   <= r_data[w_req_idx][w_req_off];
            end else begin
              r_state    <= S_REFILL;
              r_cnt      <= '0;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {w_req_tag, w_req_idx, {LINE_WORDS_LOG{1'b0}}, 2'b00};
            end
          end
        end
        S_REFILL: begin
          if (i_flush) r_squash <= 1'b1;
          if (bus.mem_done) begin
            if (&r_cnt) begin
              r_valid[w_ref_idx] <= 1'b1;
              r_state            <= S_DONE;
              r_mem_req          <= 1'b0;
              r_success          <= !(r_squash || i_flush);
              r_instr            <= (w_ref_off == r_cnt) ? bus.mem_data
                                                         : r_data[w_ref_idx][w_ref_off];
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_mem_addr <= {w_ref_tag, w_ref_idx, r_cnt + 1'b1, 2'b00};
            end
          end
        end
        S_DONE: begin
          r_success <= 1'b0;
          r_squash  <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_word_wr) begin
      r_data[w_ref_idx][r_cnt] <= bus.mem_data;
      if (&r_cnt) r_tag[w_ref_idx] <= w_ref_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        if (o_hit_cnt != 32'hFFFF_FFFF) o_hit_cnt <= o_hit_cnt + 32'd1;
      end else begin
        if (o_miss_cnt != 32'hFFFF_FFFF) o_miss_cnt <= o_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed vector table, multi-cycle corner
// sequences (flush, stall, reset mid-refill) and random fetches against a cache model.
module tb_icache_responder;

  logic clk = 1'b0;
  logic rst_n, rdy, flush;
  always #5 clk = ~clk;

  icache_responder_if bus();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_responder dut (
    .clk(clk), .rst_n(rst_n), .i_rdy(rdy), .i_flush(flush), .bus(bus)
`ifdef ICACHE_STATS_EN
    , .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
`endif
  );

  int n_cmp = 0, n_bad = 0;
  int succ_cnt = 0, exp_succ = 0;
  int resp_mode = 0;
  int wait_cnt = 0;
  logic consumed = 1'b0;
  logic [31:0] mlog[$];

  bit          mv [64];
  logic [21:0] mt [64];
  int m_hits = 0, m_miss = 0;

  typedef struct {
    logic [31:0] pc;
    bit          hit;
    logic [31:0] instr;
    int          flush_w;
    int          stall_w;
    int          lat;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'h10) return 32'h11 * ({30'b0, w[3:2]} + 32'd1);
    return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return mv[pc[9:4]] && (mt[pc[9:4]] == pc[31:10]);
  endfunction

  function automatic void model_fill(input logic [31:0] pc);
    mv[pc[9:4]] = 1'b1;
    mt[pc[9:4]] = pc[31:10];
  endfunction

  function automatic int pick();
    return (resp_mode == 1) ? int'($urandom_range(0, 3)) : 0;
  endfunction

  always @(negedge clk) begin
    consumed = rst_n && rdy && bus.mem_req && bus.mem_done;
    if (consumed) mlog.push_back(bus.mem_addr);
    if (rst_n && bus.fetch_success) succ_cnt++;
  end

  // Memory controller: answers while mem_req is high after a per-word wait.
  initial begin
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!bus.mem_req) begin
        bus.mem_done = 1'b0;
        wait_cnt = pick();
      end else begin
        if (bus.mem_done && consumed) wait_cnt = pick();
        if (wait_cnt == 0) bus.mem_done = 1'b1;
        else begin
          bus.mem_done = 1'b0;
          wait_cnt--;
        end
      end
      bus.mem_data = mem_word(bus.mem_addr);
    end
  end

  task automatic run_fetch(input logic [31:0] pc, input int flush_w, input int stall_w,
                           output bit seen, output logic [31:0] instr, output int lat);
    bit acted = 0;
    int tail = 0;
    logic [31:0] saved;
    seen = 0; instr = '0; lat = -1;
    @(posedge clk); #1;
    mlog.delete();
    bus.fetch_en = 1'b1;
    bus.fetch_pc = pc;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (bus.fetch_success) begin
        seen = 1; instr = bus.instr_out; lat = cyc;
        break;
      end
      if (!acted && flush_w >= 0 && mlog.size() == flush_w && bus.mem_req) begin
        acted = 1;
        @(posedge clk); #1;
        flush = 1'b1; bus.fetch_en = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
      end
      if (!acted && stall_w >= 0 && mlog.size() == stall_w && bus.mem_req) begin
        acted = 1;
        @(posedge clk); #1;
        rdy = 1'b0;
        saved = bus.mem_addr;
        repeat (3) begin
          @(negedge clk);
          chk("stall_addr_held", bus.mem_addr, saved);
          chk("stall_req_held", {31'b0, bus.mem_req}, 32'd1);
          chk("stall_no_success", {31'b0, bus.fetch_success}, 32'd0);
        end
        @(posedge clk); #1;
        rdy = 1'b1;
      end
      if (acted && flush_w >= 0 && mlog.size() == 4 && !bus.mem_req) begin
        tail++;
        if (tail > 4) break;
      end
    end
    @(posedge clk); #1;
    bus.fetch_en = 1'b0;
    @(negedge clk);
    chk("success_single_pulse", {31'b0, bus.fetch_success}, 32'd0);
  endtask

  task automatic check_refill(input string nm, input logic [31:0] pc, input bit hit);
    chk({nm, "_words"}, mlog.size(), hit ? 32'd0 : 32'd4);
    if (!hit)
      for (int k = 0; k < mlog.size() && k < 4; k++)
        chk({nm, "_addr"}, mlog[k], {pc[31:4], 4'h0} + 32'(4 * k));
  endtask

  initial begin
    bit          seen;
    logic [31:0] instr, pc;
    int          lat;
    bit          eh;

    vt[0] = '{32'h0000_0000, 1'b0, 32'h11,             -1, -1, 5};
    vt[1] = '{32'h0000_0008, 1'b1, 32'h33,             -1, -1, 1};
    vt[2] = '{32'h0000_0400, 1'b0, mem_word(32'h400),  -1, -1, 5};
    vt[3] = '{32'h0000_0000, 1'b0, 32'h11,             -1, -1, 5};
    vt[4] = '{32'h0000_0408, 1'b0, 32'h0,               1, -1, -1};
    vt[5] = '{32'h0000_040E, 1'b1, mem_word(32'h40C),  -1, -1, 1};
    vt[6] = '{32'h0000_0024, 1'b0, mem_word(32'h24),   -1,  1, -1};
    vt[7] = '{32'h0000_002C, 1'b1, mem_word(32'h2C),   -1, -1, 1};

    for (int i = 0; i < 64; i++) begin mv[i] = 0; mt[i] = '0; end
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.fetch_en = 1'b0; bus.fetch_pc = '0;
    repeat (3) @(negedge clk);
    chk("reset_success", {31'b0, bus.fetch_success}, 32'd0);
    chk("reset_instr", bus.instr_out, 32'd0);
    chk("reset_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_fetch(vt[i].pc, vt[i].flush_w, vt[i].stall_w, seen, instr, lat);
      eh = (vt[i].flush_w < 0);
      chk($sformatf("vec%0d_success", i), {31'b0, seen}, {31'b0, eh});
      if (eh) chk($sformatf("vec%0d_instr", i), instr, vt[i].instr);
      if (vt[i].lat >= 0) chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      check_refill($sformatf("vec%0d", i), vt[i].pc, vt[i].hit);
      chk($sformatf("vec%0d_req_idle", i), {31'b0, bus.mem_req}, 32'd0);
      if (eh) exp_succ++;
      if (vt[i].hit) m_hits++; else m_miss++;
      if (!vt[i].hit) model_fill(vt[i].pc);
`ifdef ICACHE_STATS_EN
      if (i == 1) begin
        chk("stats_hit_after_2", hit_cnt, 32'd1);
        chk("stats_miss_after_2", miss_cnt, 32'd1);
      end
`endif
    end

    // Reset in the middle of a refill.
    @(posedge clk); #1;
    mlog.delete();
    bus.fetch_en = 1'b1; bus.fetch_pc = 32'h0000_0104;
    for (int c = 0; c < 50 && mlog.size() < 2; c++) @(negedge clk);
    chk("rst_mid_reached", mlog.size(), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mid_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mid_success", {31'b0, bus.fetch_success}, 32'd0);
    bus.fetch_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) mv[i] = 0;
    m_hits = 0; m_miss = 0;
`ifdef ICACHE_STATS_EN
    chk("stats_cleared_hit", hit_cnt, 32'd0);
    chk("stats_cleared_miss", miss_cnt, 32'd0);
`endif
    run_fetch(32'h0000_0104, -1, -1, seen, instr, lat);
    chk("post_rst_success", {31'b0, seen}, 32'd1);
    chk("post_rst_instr", instr, mem_word(32'h104));
    chk("post_rst_latency", lat, 32'd5);
    check_refill("post_rst", 32'h104, 1'b0);
    exp_succ++; m_miss++; model_fill(32'h104);
    run_fetch(32'h0000_0008, -1, -1, seen, instr, lat);
    chk("post_rst_line0_success", {31'b0, seen}, 32'd1);
    chk("post_rst_line0_instr", instr, 32'h33);
    check_refill("post_rst_line0", 32'h8, 1'b0);
    exp_succ++; m_miss++; model_fill(32'h8);

    // Random fetches with random memory latency.
    resp_mode = 1;
    for (int n = 0; n < 60; n++) begin
      pc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      eh = model_hit(pc);
      run_fetch(pc, -1, -1, seen, instr, lat);
      chk("rand_success", {31'b0, seen}, 32'd1);
      chk("rand_instr", instr, mem_word(pc));
      if (eh) chk("rand_hit_latency", lat, 32'd1);
      check_refill("rand", pc, eh);
      exp_succ++;
      if (eh) m_hits++; else begin m_miss++; model_fill(pc); end
    end

    chk("total_success_pulses", succ_cnt, exp_succ);
`ifdef ICACHE_STATS_EN
    chk("stats_final_hit", hit_cnt, m_hits);
    chk("stats_final_miss", miss_cnt, m_miss);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
